// File: rtl/two_phase_clock_monitor.sv
// ============================================================================
// two_phase_clock_monitor
// Receive-end checker for a two-phase enable pair: lock, phase, error class/count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module two_phase_clock_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ph1,
  input  logic             ph2,
  input  logic             clr_err,
  output logic             locked,
  output logic             phase,
  output logic             err_pulse,
  output logic [1:0]       err_type,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);

  localparam logic [1:0] ERR_OVERLAP = 2'b01;
  localparam logic [1:0] ERR_GAP     = 2'b10;
  localparam logic [1:0] ERR_STALL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       prev_q, prev_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             idle_q, idle_d;
  logic             phase_q, phase_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_type_q, err_type_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             cur_legal;
  logic             prev_legal;
  logic             good;
  logic [1:0]       bad_class;
  logic             lock_loss;

  // A legal sample has exactly one phase active, so XOR-reduce detects it.
  always_comb begin
    cur_legal  = ^cur_q;
    prev_legal = ^prev_q;
    good       = cur_legal && prev_legal && (cur_q != prev_q);
    if (cur_q == 2'b11) begin
      bad_class = ERR_OVERLAP;
    end else if (cur_q == 2'b00) begin
      bad_class = ERR_GAP;
    end else begin
      bad_class = ERR_STALL;
    end
  end

  always_comb begin
    cur_d       = {ph1, ph2};
    prev_d      = cur_q;
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    idle_d      = idle_q;
    phase_d     = 1'b0;
    err_pulse_d = 1'b0;
    err_type_d  = err_type_q;
    lock_loss   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Two edges are needed before both cur and prev hold real samples.
        if (idle_q) begin
          state_d = ST_ACQ;
        end else begin
          idle_d = 1'b1;
        end
      end
      ST_ACQ: begin
        if (good) begin
          if (gcnt_q == LOCK_LAST) begin
            state_d = ST_LOCK;
            gcnt_d  = 8'd0;
            phase_d = cur_q[1];
          end else begin
            gcnt_d = gcnt_q + 8'd1;
          end
        end else begin
          gcnt_d = 8'd0;
        end
      end
      ST_LOCK: begin
        if (good) begin
          phase_d = cur_q[1];
        end else begin
          state_d     = ST_ACQ;
          gcnt_d      = 8'd0;
          err_pulse_d = 1'b1;
          err_type_d  = bad_class;
          lock_loss   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idle_d  = 1'b0;
      end
    endcase

    // Clear wins over a coincident increment.
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (lock_loss && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= 2'b00;
      prev_q      <= 2'b00;
      gcnt_q      <= 8'd0;
      idle_q      <= 1'b0;
      phase_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_type_q  <= 2'b00;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      gcnt_q      <= gcnt_d;
      idle_q      <= idle_d;
      phase_q     <= phase_d;
      err_pulse_q <= err_pulse_d;
      err_type_q  <= err_type_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == ST_LOCK);
  assign phase     = phase_q;
  assign err_pulse = err_pulse_q;
  assign err_type  = err_type_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_two_phase_clock_monitor.sv
// ============================================================================
// tb_two_phase_clock_monitor
// Table vectors, directed corner sequences and random stimulus vs. a streak model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_two_phase_clock_monitor;

  localparam int LOCK_CNT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       clr_err = 1'b0;

  logic       a_locked, a_phase, a_pulse;
  logic [1:0] a_type;
  logic [7:0] a_cnt;
  logic       b_locked, b_phase, b_pulse;
  logic [1:0] b_type;
  logic [1:0] b_cnt;

  two_phase_clock_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ph1(ph1), .ph2(ph2), .clr_err(clr_err),
    .locked(a_locked), .phase(a_phase), .err_pulse(a_pulse),
    .err_type(a_type), .err_cnt(a_cnt)
  );

  two_phase_clock_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ph1(ph1), .ph2(ph2), .clr_err(clr_err),
    .locked(b_locked), .phase(b_phase), .err_pulse(b_pulse),
    .err_type(b_type), .err_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: lock holds exactly while the trailing run of good classifications
  // is at least LOCK_CNT long.
  int         m_edges;
  int         m_streak;
  logic [1:0] m_cur, m_prev, m_type;
  logic       m_pulse, m_phase, m_locked;
  int         m_cnt_a, m_cnt_b;
  logic       alt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_streak = 0; m_cur = 2'b00; m_prev = 2'b00; m_type = 2'b00;
    m_pulse = 1'b0; m_phase = 1'b0; m_locked = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  function automatic bit legal(input logic [1:0] s);
    return (s == 2'b10) || (s == 2'b01);
  endfunction

  task automatic model_edge(input logic [1:0] smp, input logic clr);
    bit good;
    m_pulse = 1'b0;
    if (m_edges >= 2) begin
      good = legal(m_cur) && legal(m_prev) && (m_cur != m_prev);
      if (good) begin
        if (m_streak < 1000) m_streak++;
      end else begin
        if (m_streak >= LOCK_CNT) begin
          m_pulse = 1'b1;
          m_type  = (m_cur == 2'b11) ? 2'b01 : (m_cur == 2'b00) ? 2'b10 : 2'b11;
        end
        m_streak = 0;
      end
    end
    m_locked = (m_streak >= LOCK_CNT);
    m_phase  = m_locked ? m_cur[1] : 1'b0;
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_pulse) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    m_prev = m_cur;
    m_cur  = smp;
    m_edges++;
  endtask

  task automatic compare_all();
    chk("a_locked", a_locked, m_locked);
    chk("a_phase",  a_phase,  m_phase);
    chk("a_pulse",  a_pulse,  m_pulse);
    chk("a_type",   a_type,   m_type);
    chk("a_cnt",    a_cnt,    m_cnt_a);
    chk("b_locked", b_locked, m_locked);
    chk("b_phase",  b_phase,  m_phase);
    chk("b_pulse",  b_pulse,  m_pulse);
    chk("b_type",   b_type,   m_type);
    chk("b_cnt",    b_cnt,    m_cnt_b);
  endtask

  task automatic step(input logic [1:0] smp, input logic clr);
    ph1 = smp[1]; ph2 = smp[0]; clr_err = clr;
    @(posedge clk);
    model_edge(smp, clr);
    #1;
    compare_all();
  endtask

  task automatic alt_steps(input int n);
    for (int i = 0; i < n; i++) begin
      alt = ~alt;
      step(alt ? 2'b10 : 2'b01, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    alt = 1'b0;
  endtask

  typedef struct {
    logic [1:0] smp;
    logic       clr;
    logic       e_locked;
    logic       e_phase;
    logic       e_pulse;
    logic [1:0] e_type;
    int         e_cnt;
  } vec_t;

  vec_t tbl[29];

  initial begin
    int pulses;
    int rr;
    logic [1:0] last_smp;

    // Edge k of the run is table entry k-1; fault (overlap) at edge 20.
    for (int k = 1; k <= 29; k++) begin
      tbl[k-1].smp      = (k == 20) ? 2'b11 : ((k % 2) == 1) ? 2'b10 : 2'b01;
      tbl[k-1].clr      = 1'b0;
      tbl[k-1].e_locked = (k >= 6) && !((k >= 21) && (k <= 25));
      tbl[k-1].e_phase  = tbl[k-1].e_locked ? (((k - 1) % 2) == 1) : 1'b0;
      tbl[k-1].e_pulse  = (k == 21);
      tbl[k-1].e_type   = (k >= 21) ? 2'b01 : 2'b00;
      tbl[k-1].e_cnt    = (k >= 21) ? 1 : 0;
    end

    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", a_locked, 1'b0);
    chk("rst_phase",  a_phase,  1'b0);
    chk("rst_pulse",  a_pulse,  1'b0);
    chk("rst_type",   a_type,   2'b00);
    chk("rst_cnt",    a_cnt,    8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].smp, tbl[i].clr);
      chk("tbl_locked", a_locked, tbl[i].e_locked);
      chk("tbl_phase",  a_phase,  tbl[i].e_phase);
      chk("tbl_pulse",  a_pulse,  tbl[i].e_pulse);
      chk("tbl_type",   a_type,   tbl[i].e_type);
      chk("tbl_cnt",    a_cnt,    tbl[i].e_cnt);
    end

    // Stall: 10 held over edges 30..32 (edge 29 was also 10), then alternation.
    pulses = 0;
    for (int e = 30; e <= 44; e++) begin
      step((e <= 32) ? 2'b10 : ((e % 2) == 1) ? 2'b01 : 2'b10, 1'b0);
      if (a_pulse) pulses++;
      if (e == 36) chk("stall_not_yet_locked", a_locked, 1'b0);
      if (e == 37) chk("stall_relock", a_locked, 1'b1);
    end
    chk("stall_pulses", pulses, 1);
    chk("stall_type",   a_type, 2'b11);
    chk("stall_cnt",    a_cnt,  8'd2);

    // Saturation of the narrow counter over five gap faults.
    do_reset();
    alt_steps(8);
    for (int i = 1; i <= 5; i++) begin
      step(2'b00, 1'b0);
      alt_steps(1);
      chk("sat_pulse", b_pulse, 1'b1);
      chk("sat_type",  b_type,  2'b10);
      chk("sat_cnt_b", b_cnt,   (i > 3) ? 3 : i);
      chk("sat_cnt_a", a_cnt,   i);
      alt_steps(8);
      chk("sat_relock", a_locked, 1'b1);
    end

    // Clear coinciding with a lock-loss classification.
    step(2'b11, 1'b0);
    alt = ~alt;
    step(alt ? 2'b10 : 2'b01, 1'b1);
    chk("clr_cnt",   a_cnt,   8'd0);
    chk("clr_pulse", a_pulse, 1'b1);
    chk("clr_type",  a_type,  2'b01);
    alt_steps(8);

    // Asynchronous reset while locked with two errors counted.
    for (int i = 0; i < 2; i++) begin
      step(2'b00, 1'b0);
      alt_steps(8);
    end
    chk("pre_rst_cnt", a_cnt, 8'd2);
    chk("pre_rst_locked", a_locked, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", a_locked, 1'b0);
    chk("arst_phase",  a_phase,  1'b0);
    chk("arst_type",   a_type,   2'b00);
    chk("arst_cnt",    a_cnt,    8'd0);
    chk("arst_cnt_b",  b_cnt,    2'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    alt = 1'b0;
    alt_steps(5);
    chk("rerun_edge5", a_locked, 1'b0);
    alt_steps(1);
    chk("rerun_edge6", a_locked, 1'b1);

    // Random: mostly alternation, with random faults, holds and clears.
    last_smp = alt ? 2'b10 : 2'b01;
    for (int i = 0; i < 2000; i++) begin
      rr = $urandom_range(0, 99);
      if (rr < 5) begin
        last_smp = 2'($urandom_range(0, 3));
      end else if (rr < 8) begin
        last_smp = last_smp;
      end else begin
        alt = ~alt;
        last_smp = alt ? 2'b10 : 2'b01;
      end
      step(last_smp, ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/two_phase_clock_monitor.md
# two_phase_clock_monitor

Checks the pair of phase-enable lines produced by the team's two-phase clock generator. Each `clk` cycle it samples the two lines and verifies that they are complementary and alternate every cycle. It acquires lock after a programmable run of good cycles and reports the active phase while locked. Each loss of lock is flagged, classified and counted. It sits on the clock-consuming side of the generator as the receive-end checker.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive good classifications required to enter LOCK. Legal range is 2 to 255.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk` in, 1: single clock; everything is clocked on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ph1` in, 1: phase-1 enable, synchronous to `clk`.
- `ph2` in, 1: phase-2 enable, synchronous to `clk`.
- `clr_err` in, 1: synchronous clear of `err_cnt`.
- `locked` out, 1: monitor is in LOCK.
- `phase` out, 1: registered `ph1` value of the last classified sample. Forced to 0 when not locked.
- `err_pulse` out, 1: one-cycle strobe on each loss of lock.
- `err_type` out, 2: class of the last lock loss. 01 = overlap, 10 = gap, 11 = stall.
- `err_cnt` out, ERR_W: number of lock losses, saturating.

## Operation
- Sample pipeline, at every edge:
  - `cur <= {ph1,ph2}`
  - `prev <= cur`
- Legal sample: `cur` is 10 or 01.
- Good classification: `cur` is legal, `prev` is legal, and `cur != prev`.
- Bad classification, by priority:
  - `cur` = 11 is overlap.
  - `cur` = 00 is gap.
  - Otherwise (illegal `prev`, or `cur == prev`) is stall.
- FSM states are IDLE, ACQ and LOCK. Good-run counter `gcnt` is 8 bits.
  - IDLE: fills the pipeline. Moves to ACQ at the 2nd edge after reset release. No classification is done in IDLE.
  - ACQ, good classification with `gcnt == LOCK_CNT-1`: go to LOCK and clear `gcnt`.
  - ACQ, other good classification: `gcnt++`.
  - ACQ, bad classification: `gcnt <= 0` and stay in ACQ. No error is reported in ACQ.
  - LOCK, good classification: stay in LOCK.
  - LOCK, bad classification: go to ACQ with `gcnt <= 0`. Assert `err_pulse` and load `err_type`. Increment `err_cnt`, saturating at all-ones.
- `err_type` holds its value until the next lock loss.
- `clr_err` has priority over increment. If it coincides with an error, `err_cnt` becomes 0, but `err_pulse` and `err_type` still update.
- `phase` equals `cur[1]` as registered on the edge where the classification was good in LOCK, or on the LOCK entry edge. It is 0 otherwise.

## Timing
- Reset values, all applied asynchronously:
  - `locked` = 0, `phase` = 0, `err_pulse` = 0, `err_type` = 00, `err_cnt` = 0
  - `cur`/`prev` = 00, `gcnt` = 0, state = IDLE
- Reset asserted mid-operation clears everything immediately. Acquisition restarts from IDLE on release.
- Input-to-classification latency: a sample registered at edge k is classified at edge k+1. Outputs change after edge k+1.
- With continuous legal alternation from reset release, `locked` rises after edge LOCK_CNT+2. For LOCK_CNT=4 that is edge 6.
- Single bad sample at edge k while locked:
  - After edge k+1: `err_pulse` = 1 for exactly one cycle and `locked` = 0. These happen on the same edge.
  - Classifications at k+1 and k+2 are bad (bad `cur`, then bad `prev`). They are not counted.
  - Relock after edge k+LOCK_CNT+2.
- A persistent fault causes exactly one `err_pulse`. It is counted once, because errors are counted only in LOCK.
- Saturation: `err_cnt` at 2^ERR_W−1 holds on further errors. `err_pulse` still fires.
- `clr_err` takes effect at the next edge. `err_cnt` reads 0 after that edge.

## Test plan
- Reset release, then alternating 10/01 from edge 1, with LOCK_CNT=4 → `locked` rises after edge 6. `phase` tracks `ph1` delayed by 2 edges. `err_cnt` = 0.
- Locked, one sample forced to 11 at edge 20 → `err_pulse` high after edge 21 only, `err_type` = 01, `err_cnt` = 1. `locked` is low after edge 21 and high again after edge 26.
- Locked, `ph1`/`ph2` held at 10 for 3 cycles starting edge 30 → a single `err_pulse`, `err_type` = 11, `err_cnt` +1, relock 4 good classifications after alternation resumes.
- ERR_W=2, inject 5 separate gap (00) faults, each followed by relock → `err_cnt` sequence 1,2,3,3,3. Five pulses, `err_type` = 10.
- `clr_err` asserted on the same edge as a lock-loss classification → `err_cnt` = 0 afterwards, `err_pulse` = 1, `err_type` updated.
- `rst_n` pulsed low while locked with `err_cnt` = 2 → all outputs are 0 immediately, without waiting for a clock edge. Relock after edge 6 of the new run.
